// File: rtl/lfsr_prog_ctrl.sv
// lfsr_prog_ctrl: program sequencer for the 8-bit tap-configurable LFSR.
// Fetches 14-bit instructions {opcode[13:8], operand[7:0]} from an
// asynchronous ROM and issues single-cycle strobes to the LFSR and to the
// pattern memory. It also owns the pattern-memory address register.
// Optional build macro: LFSR_PROG_CTRL_SINGLE_STEP_EN adds the step_go input
// and a PAUSE state. In that state the FSM waits after every instruction.
module lfsr_prog_ctrl #(
  parameter int PC_W   = 6,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef LFSR_PROG_CTRL_SINGLE_STEP_EN
  input  logic              step_go,
`endif
  output logic [PC_W-1:0]   imem_addr,
  input  logic [13:0]       imem_data,
  output logic [6:0]        lfsr_tap,
  output logic              lfsr_tap_we,
  output logic [DATA_W-1:0] lfsr_seed,
  output logic              lfsr_seed_we,
  output logic              lfsr_step,
  output logic              lfsr_load,
  output logic [DATA_W-1:0] lfsr_load_data,
  input  logic [DATA_W-1:0] lfsr_state,
  input  logic [3:0]        lfsr_hd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              halted,
  output logic              err_illegal
);

  localparam logic [5:0] OP_HALT      = 6'h00;
  localparam logic [5:0] OP_CONFIG    = 6'h01;
  localparam logic [5:0] OP_INIT      = 6'h02;
  localparam logic [5:0] OP_RUN       = 6'h03;
  localparam logic [5:0] OP_INIT_ADDR = 6'h04;
  localparam logic [5:0] OP_ST_L      = 6'h05;
  localparam logic [5:0] OP_ADD_ADDR  = 6'h06;
  localparam logic [5:0] OP_LD_L      = 6'h07;
  localparam logic [5:0] OP_ST_HD     = 6'h08;

`ifdef LFSR_PROG_CTRL_SINGLE_STEP_EN
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, RUN, LDWB, HALT, PAUSE} state_t;
  // Completed instructions park in PAUSE until step_go
  localparam state_t NEXT_INSTR = PAUSE;
`else
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, RUN, LDWB, HALT} state_t;
  localparam state_t NEXT_INSTR = FETCH;
`endif

  state_t            state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [13:0]       ir_reg;
  logic [ADDR_W-1:0] r_addr_reg;
  logic [7:0]        cnt_reg;
  logic              busy_reg;
  logic              halted_reg;
  logic              err_illegal_reg;

  logic [5:0] opcode;
  logic [7:0] operand;

  assign opcode      = ir_reg[13:8];
  assign operand     = ir_reg[7:0];
  assign imem_addr   = pc_reg;
  assign mem_addr    = r_addr_reg;
  assign busy        = busy_reg;
  assign halted      = halted_reg;
  assign err_illegal = err_illegal_reg;

  // Sequencer FSM: pc, instruction register, address register, run counter and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      ir_reg          <= '0;
      r_addr_reg      <= '0;
      cnt_reg         <= '0;
      busy_reg        <= 1'b0;
      halted_reg      <= 1'b0;
      err_illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= FETCH;
            pc_reg    <= '0;
            busy_reg  <= 1'b1;
          end
        end
        FETCH: begin
          ir_reg    <= imem_data;
          state_reg <= EXEC;
        end
        EXEC: begin
          if (opcode == OP_HALT) begin
            state_reg  <= HALT;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b1;
          end else if (opcode > OP_ST_HD) begin
            err_illegal_reg <= 1'b1;
            state_reg       <= HALT;
            busy_reg        <= 1'b0;
            halted_reg      <= 1'b1;
          end else begin
            pc_reg    <= pc_reg + PC_W'(1);
            state_reg <= NEXT_INSTR;
            case (opcode)
              OP_RUN: begin
                // The EXEC cycle issues the first step; RUN covers the remaining N-1
                if (operand != 8'd0) cnt_reg <= operand - 8'd1;
                if (operand > 8'd1) state_reg <= RUN;
              end
              OP_INIT_ADDR: r_addr_reg <= ADDR_W'(operand);
              OP_ADD_ADDR:  r_addr_reg <= r_addr_reg + ADDR_W'(operand);
              OP_LD_L:      state_reg  <= LDWB;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) state_reg <= NEXT_INSTR;
        end
        LDWB: state_reg <= NEXT_INSTR;
        HALT: begin
          if (start) begin
            state_reg  <= FETCH;
            pc_reg     <= '0;
            busy_reg   <= 1'b1;
            halted_reg <= 1'b0;
          end
        end
`ifdef LFSR_PROG_CTRL_SINGLE_STEP_EN
        PAUSE: begin
          if (step_go) state_reg <= FETCH;
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Strobes and their data are decoded directly from state and ir and last one cycle each
  always_comb begin
    lfsr_tap       = '0;
    lfsr_tap_we    = 1'b0;
    lfsr_seed      = '0;
    lfsr_seed_we   = 1'b0;
    lfsr_step      = 1'b0;
    lfsr_load      = 1'b0;
    lfsr_load_data = '0;
    mem_we         = 1'b0;
    mem_wdata      = '0;
    mem_re         = 1'b0;
    if (state_reg == EXEC) begin
      case (opcode)
        OP_CONFIG: begin
          lfsr_tap    = operand[6:0];
          lfsr_tap_we = 1'b1;
        end
        OP_INIT: begin
          lfsr_seed    = DATA_W'(operand);
          lfsr_seed_we = 1'b1;
        end
        OP_RUN:   lfsr_step = (operand != 8'd0);
        OP_ST_L: begin
          mem_we    = 1'b1;
          mem_wdata = lfsr_state;
        end
        OP_LD_L:  mem_re = 1'b1;
        OP_ST_HD: begin
          mem_we    = 1'b1;
          mem_wdata = DATA_W'({4'b0000, lfsr_hd});
        end
        default: ;
      endcase
    end
    if (state_reg == RUN) lfsr_step = 1'b1;
    if (state_reg == LDWB) begin
      lfsr_load      = 1'b1;
      lfsr_load_data = mem_rdata;
    end
  end

endmodule

// File: doc/lfsr_prog_ctrl.md
Name: lfsr_prog_ctrl

Overview:
- Program sequencer for the 8-bit tap-configurable LFSR datapath.
- Fetches 14-bit instructions (opcode[13:8], operand[7:0]) from an asynchronous instruction ROM and decodes them.
- Issues single-cycle strobes to the LFSR: tap config, seed load, shift step, parallel load.
- Owns the pattern-memory address register and memory strobes, replacing the per-pc decode currently embedded in the datapath.

Parameters:
- PC_W, 6, program counter width; program depth is 2**PC_W.
- ADDR_W, 8, pattern-memory address width.
- DATA_W, 8, LFSR and pattern-memory data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin execution at pc 0; ignored while busy
- imem_addr  out  PC_W  instruction address (= pc)
- imem_data  in  14  instruction, combinationally valid for imem_addr
- lfsr_tap  out  7  tap vector
- lfsr_tap_we  out  1  tap load strobe
- lfsr_seed  out  DATA_W  seed value
- lfsr_seed_we  out  1  seed load strobe
- lfsr_step  out  1  one LFSR shift per asserted cycle
- lfsr_load  out  1  parallel-load strobe
- lfsr_load_data  out  DATA_W  parallel-load value
- lfsr_state  in  DATA_W  current pattern P
- lfsr_hd  in  4  Hamming distance P vs P_next
- mem_addr  out  ADDR_W  pattern-memory address (= r_addr)
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_re  out  1  memory read strobe
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_re
- busy  out  1  high from start until HALT
- halted  out  1  high in HALT state
- err_illegal  out  1  sticky; illegal opcode seen

Behaviour:
- Reset (rst_n low at posedge):
  - State IDLE; pc=0, r_addr=0, cnt=0.
  - All strobes 0; lfsr_tap, lfsr_seed and lfsr_load_data 0; busy, halted and err_illegal 0.
  - Reset mid-RUN or mid-LOAD aborts the operation; no further strobes are issued.
- FSM states: IDLE, FETCH, EXEC, RUN, LDWB, HALT.
- IDLE:
  - start=1 -> FETCH, pc=0, busy=1.
- FETCH:
  - ir <= imem_data -> EXEC.
- EXEC: decode ir; all strobes are combinational from state/ir and last one cycle.
  - 0x00 halt -> HALT.
  - 0x01 config: lfsr_tap=operand[6:0], lfsr_tap_we=1.
  - 0x02 init: lfsr_seed=operand, lfsr_seed_we=1.
  - 0x03 run N:
    - N=0: no step.
    - N>=1: lfsr_step=1 this cycle, cnt<=N-1; if N>1 -> RUN.
    - Exactly N step cycles in total.
  - 0x04 init_addr: r_addr<=operand.
  - 0x05 st_M_L: mem_we=1, mem_wdata=lfsr_state.
  - 0x06 add_addr: r_addr<=(r_addr+operand) mod 2**ADDR_W; e.g. 0xFE acts as -2.
  - 0x07 ld_M_L: mem_re=1 -> LDWB.
  - 0x08 st_M_HD: mem_we=1, mem_wdata={0000,lfsr_hd}.
  - 0x09-0x3F: err_illegal<=1 -> HALT.
  - Every op except halt and illegal increments pc (wraps 2**PC_W-1 -> 0) and goes to FETCH unless a RUN/LDWB state is entered.
- RUN:
  - lfsr_step=1 each cycle; cnt decrements.
  - At cnt==1 the last step is issued -> FETCH.
- LDWB:
  - lfsr_load=1, lfsr_load_data=mem_rdata -> FETCH.
- HALT:
  - halted=1, busy=0.
  - start -> FETCH with pc=0; err_illegal is not cleared (reset only).
- Latency:
  - Single-cycle ops take 2 cycles (FETCH+EXEC).
  - run N takes 1+max(N,1) cycles.
  - ld_M_L takes 3 cycles.
- Ordering:
  - mem_addr is the r_addr registered before the EXEC edge, so add_addr takes effect for the next instruction.
  - st_M_L samples lfsr_state in EXEC, after all prior steps have settled.

Optional Feature:
- LFSR_PROG_CTRL_SINGLE_STEP_EN:
  - When defined: adds input step_go (1 bit) and state PAUSE.
  - After each instruction completes (the transition that would enter FETCH), the FSM enters PAUSE and issues no strobes.
  - A step_go pulse then moves it to FETCH.
  - busy stays 1 in PAUSE.
- When undefined: no port and no state; the FSM goes directly to FETCH.

Test Plan:
- Reset then start with ROM {config 0x25; init 0xFF; halt}:
  - lfsr_tap_we one cycle with tap=0x25.
  - lfsr_seed_we one cycle with seed=0xFF.
  - halted=1 at cycle 7, pc=2.
- run 0x0B: exactly 11 consecutive lfsr_step cycles; run 0x00: zero steps, pc advances.
- init_addr 0x09; add_addr 0xFE; st_M_L -> mem_we at mem_addr 0x07 with mem_wdata=lfsr_state.
- ld_M_L with mem_rdata=0xA5 the cycle after mem_re -> lfsr_load=1 with data 0xA5 one cycle later.
- Opcode 0x3F -> err_illegal=1, halted=1; err_illegal stays 1 after restart; only reset clears it.
- rst_n low during run 0xFF after 10 steps -> lfsr_step=0 on the next cycle, state IDLE, busy=0, r_addr=0.
